// File: rtl/hs_seq_pkg.sv
// Shared types and helpers for the HLS stage sequencer.
package hs_seq_pkg;

    // Top-level sequencer states
    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } seq_state_t;

    // Index width for n stages, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hs_seq_pick_next.sv
// Priority encoder: lowest enabled stage above the current index, or the
// lowest enabled stage overall when search_all_i is set (used at accept).
module hs_seq_pick_next #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned IDX_W      = 2
) (
    input  logic [NUM_STAGES-1:0] mask_i,
    input  logic [IDX_W-1:0]      cur_i,
    input  logic                  search_all_i,
    output logic [IDX_W-1:0]      next_o,
    output logic                  none_o
);

    // Scan from the top down so the lowest qualifying index wins
    always_comb begin
        next_o = '0;
        none_o = 1'b1;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (mask_i[i] && (search_all_i || (i > int'(cur_i)))) begin
                next_o = IDX_W'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hs_stage_sequencer.sv
// Runs a chain of ap_ctrl_hs sub-blocks one at a time under a single
// ap_ctrl_hs handshake, with stage masking, a per-stage watchdog and
// saturating per-stage / total cycle counters for on-board profiling.
module hs_stage_sequencer
    import hs_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned IDX_W      = idx_w(NUM_STAGES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic [NUM_STAGES-1:0] stage_en,
    input  logic [CNT_W-1:0]      timeout_cycles,
    output logic [NUM_STAGES-1:0] stg_start,
    input  logic [NUM_STAGES-1:0] stg_ready,
    input  logic [NUM_STAGES-1:0] stg_done,
    output logic                  err_timeout,
    output logic [IDX_W-1:0]      err_stage,
    input  logic [IDX_W-1:0]      cnt_sel,
    output logic [CNT_W-1:0]      cnt_value,
    output logic [CNT_W-1:0]      total_cycles
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CNT_W'(1);
    endfunction

    seq_state_t              state_q, state_d;
    logic [IDX_W-1:0]        cur_q, cur_d;
    logic [NUM_STAGES-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]        tmo_q, tmo_d;
    logic [CNT_W-1:0]        cnt_q [NUM_STAGES];
    logic [CNT_W-1:0]        cnt_d [NUM_STAGES];
    logic [CNT_W-1:0]        total_q, total_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        err_stg_q, err_stg_d;

    logic                    accept;
    logic                    abort;
    logic                    cur_ready, cur_done;
    logic [CNT_W-1:0]        cur_cnt;
    logic                    wd_hit;
    logic [NUM_STAGES-1:0]   pick_mask;
    logic [IDX_W-1:0]        pick_next;
    logic                    pick_none;

    assign accept    = (state_q == IDLE) && ap_start;
    assign cur_ready = stg_ready[cur_q];
    assign cur_done  = stg_done[cur_q];
    // Count of the current stage including this cycle
    assign cur_cnt   = sat_inc(cnt_q[cur_q]);
    assign wd_hit    = (tmo_q != '0) && (cur_cnt == tmo_q) && !cur_done;

    // In IDLE the live mask is searched from stage 0; later the latched mask above cur_q
    assign pick_mask = (state_q == IDLE) ? stage_en : mask_q;

    hs_seq_pick_next #(
        .NUM_STAGES (NUM_STAGES),
        .IDX_W      (IDX_W)
    ) u_pick_next (
        .mask_i       (pick_mask),
        .cur_i        (cur_q),
        .search_all_i (state_q == IDLE),
        .next_o       (pick_next),
        .none_o       (pick_none)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, current stage and watchdog abort decision
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = pick_none ? DONE : LAUNCH;
                    cur_d   = pick_next;
                end
            end
            LAUNCH, WAIT: begin
                if (wd_hit) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end else if (cur_done) begin
                    // Done in LAUNCH, with or without ready, also completes the stage
                    state_d = pick_none ? DONE : LAUNCH;
                    if (!pick_none) begin
                        cur_d = pick_next;
                    end
                end else if ((state_q == LAUNCH) && cur_ready) begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next state: latch config at accept, count cycles, record errors
    always_comb begin
        mask_d    = mask_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        err_d     = err_q;
        err_stg_d = err_stg_q;
        if (accept) begin
            mask_d    = stage_en;
            tmo_d     = timeout_cycles;
            for (int k = 0; k < NUM_STAGES; k++) begin
                cnt_d[k] = '0;
            end
            // The accept cycle counts; the DONE cycle is pre-added so the total is final in DONE
            total_d   = (state_d == DONE) ? sat_inc(CNT_W'(1)) : CNT_W'(1);
            err_d     = 1'b0;
            err_stg_d = '0;
        end else if ((state_q == LAUNCH) || (state_q == WAIT)) begin
            cnt_d[cur_q] = cur_cnt;
            total_d      = (state_d == DONE) ? sat_inc(sat_inc(total_q)) : sat_inc(total_q);
            if (abort) begin
                err_d     = 1'b1;
                err_stg_d = cur_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_q     <= '0;
            mask_q    <= '0;
            tmo_q     <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                cnt_q[k] <= '0;
            end
            total_q   <= '0;
            err_q     <= 1'b0;
            err_stg_q <= '0;
        end else begin
            cur_q     <= cur_d;
            mask_q    <= mask_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            err_q     <= err_d;
            err_stg_q <= err_stg_d;
        end
    end

    // Moore outputs: no path from stg_* inputs to stg_start
    always_comb begin
        ap_idle   = (state_q == IDLE);
        ap_done   = (state_q == DONE);
        ap_ready  = (state_q == DONE);
        stg_start = '0;
        if (state_q == LAUNCH) begin
            stg_start[cur_q] = 1'b1;
        end
        err_timeout  = err_q;
        err_stage    = err_stg_q;
        cnt_value    = cnt_q[cnt_sel];
        total_cycles = total_q;
    end

endmodule

// File: tb/tb_hs_stage_sequencer.sv
// Self-checking bench for hs_stage_sequencer: table-driven runs, a reset
// mid-run sequence and randomized runs against a per-stage duration model.
module tb_hs_stage_sequencer;

    localparam int N     = 4;
    localparam int CW    = 32;
    localparam int IW    = 2;
    localparam int NEVER = 255;

    logic          clock;
    logic          reset;
    logic          ap_start;
    logic          ap_ready, ap_done, ap_idle;
    logic [N-1:0]  stage_en;
    logic [CW-1:0] timeout_cycles;
    logic [N-1:0]  stg_start, stg_ready, stg_done;
    logic          err_timeout;
    logic [IW-1:0] err_stage;
    logic [IW-1:0] cnt_sel;
    logic [CW-1:0] cnt_value, total_cycles;

    hs_stage_sequencer #(
        .NUM_STAGES (N),
        .CNT_W      (CW),
        .IDX_W      (IW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ap_start       (ap_start),
        .ap_ready       (ap_ready),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .stage_en       (stage_en),
        .timeout_cycles (timeout_cycles),
        .stg_start      (stg_start),
        .stg_ready      (stg_ready),
        .stg_done       (stg_done),
        .err_timeout    (err_timeout),
        .err_stage      (err_stage),
        .cnt_sel        (cnt_sel),
        .cnt_value      (cnt_value),
        .total_cycles   (total_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Stage responder config: relative cycle (from first start seen) of ready and done
    int cfg_r  [N];
    int cfg_dn [N];

    // Model outputs
    int     exp_cnt [N];
    int     m_total;
    bit     m_err;
    int     m_stg;
    longint m_seq;

    typedef struct packed {
        logic [3:0]      mask;
        logic [31:0]     tmo;
        logic [3:0][7:0] r;    // stage 3 first
        logic [3:0][7:0] dn;   // 255 = never done
        logic            noise;
        logic [15:0]     x_total;
        logic            x_err;
        logic [1:0]      x_stg;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] mask, input logic [31:0] tmo,
                                 input logic [31:0] r, input logic [31:0] dn, input logic noise,
                                 input int tot, input bit err, input int stg);
        vec_t v;
        v.mask    = mask;
        v.tmo     = tmo;
        v.r       = r;
        v.dn      = dn;
        v.noise   = noise;
        v.x_total = tot[15:0];
        v.x_err   = err;
        v.x_stg   = stg[1:0];
        return v;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Each enabled stage occupies done-time+1 cycles unless the watchdog cuts it short;
    // the run costs one accept cycle and one DONE cycle on top.
    function automatic void model(input logic [3:0] mask, input logic [31:0] tmo);
        longint len;
        m_total = 1;
        m_err   = 0;
        m_stg   = 0;
        m_seq   = 0;
        for (int k = 0; k < N; k++) exp_cnt[k] = 0;
        for (int k = 0; k < N; k++) begin
            if (!m_err && mask[k]) begin
                m_seq = m_seq * 16 + k + 1;
                len = (cfg_dn[k] == NEVER) ? 64'h7fff_ffff_ffff : longint'(cfg_dn[k] + 1);
                if (tmo != 0 && longint'(tmo) < len) begin
                    exp_cnt[k] = int'(tmo);
                    m_err      = 1;
                    m_stg      = k;
                end else begin
                    exp_cnt[k] = int'(len);
                end
                m_total += exp_cnt[k];
            end
        end
        m_total += 1;
    endfunction

    // One run from accept to idle; called at posedge+1 with the DUT idle
    task automatic run_vec(input logic [3:0] mask, input logic [31:0] tmo, input bit noise,
                           input int x_total, input bit x_err, input int x_stg, input string tag);
        int act, s, cyc, rel, onehot_bad;
        bit got_done;
        longint seq;
        logic [N-1:0] prev_start;
        model(mask, tmo);
        check({tag, "/idle_before"}, 64'(ap_idle), 1);
        ap_start = 1'b1;
        stage_en = mask;
        timeout_cycles = tmo;
        stg_ready = '0;
        stg_done = '0;
        act = -1; s = 0; cyc = 0; got_done = 0; seq = 0; onehot_bad = 0; prev_start = '0;
        while (cyc < 500 && !got_done) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == 1) check({tag, "/err_clr"}, 64'(err_timeout), 0);
            if ($countones(stg_start) > 1) onehot_bad++;
            if (stg_start != '0 && stg_start != prev_start) seq = seq * 16 + onehot_idx(stg_start) + 1;
            prev_start = stg_start;
            if (ap_done) begin
                got_done = 1;
                ap_start = 1'b0;
                check({tag, "/done_cyc"}, 64'(cyc), 64'(x_total - 1));
                check({tag, "/ap_ready"}, 64'(ap_ready), 1);
            end
            stg_ready = '0;
            stg_done  = '0;
            if (act < 0 && stg_start != '0) begin
                act = onehot_idx(stg_start);
                s   = cyc;
            end
            if (act >= 0) begin
                rel = cyc - s;
                if (rel == cfg_r[act])  stg_ready[act] = 1'b1;
                if (rel == cfg_dn[act]) stg_done[act]  = 1'b1;
            end
            if (noise) begin
                for (int j = 0; j < N; j++) begin
                    if (j != act) begin
                        stg_ready[j] = ($urandom_range(0, 3) == 0);
                        stg_done[j]  = ($urandom_range(0, 3) == 0);
                    end
                end
            end
            if (act >= 0 && (cyc - s) == cfg_dn[act]) act = -1;
        end
        stg_ready = '0;
        stg_done  = '0;
        ap_start  = 1'b0;
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL %s/no_done: ap_done absent after %0d cycles, required within %0d", tag, cyc, x_total);
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            @(posedge clock); #1;
            return;
        end
        check({tag, "/total"}, 64'(total_cycles), 64'(x_total));
        check({tag, "/err"}, 64'(err_timeout), 64'(x_err));
        if (x_err) check({tag, "/err_stage"}, 64'(err_stage), 64'(x_stg));
        check({tag, "/start_seq"}, 64'(seq), 64'(m_seq));
        check({tag, "/onehot"}, 64'(onehot_bad), 0);
        @(posedge clock); #1;
        check({tag, "/done_pulse"}, 64'(ap_done), 0);
        check({tag, "/idle_after"}, 64'(ap_idle), 1);
        for (int k = 0; k < N; k++) begin
            cnt_sel = k[IW-1:0];
            #1;
            check($sformatf("%s/cnt%0d", tag, k), 64'(cnt_value), 64'(exp_cnt[k]));
        end
    endtask

    initial begin
        reset = 1'b1;
        ap_start = 1'b0;
        stage_en = '0;
        timeout_cycles = '0;
        stg_ready = '0;
        stg_done = '0;
        cnt_sel = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst/idle", 64'(ap_idle), 1);
        check("rst/done", 64'(ap_done), 0);
        check("rst/ready", 64'(ap_ready), 0);
        check("rst/start", 64'(stg_start), 0);
        check("rst/err", 64'(err_timeout), 0);
        check("rst/err_stage", 64'(err_stage), 0);
        check("rst/total", 64'(total_cycles), 0);
        for (int k = 0; k < N; k++) begin
            cnt_sel = k[IW-1:0];
            #1;
            check($sformatf("rst/cnt%0d", k), 64'(cnt_value), 0);
        end
        reset = 1'b0;
        @(posedge clock); #1;

        //            mask     tmo  r(3..0)          dn(3..0)             noise total err stg
        vecs[0]  = mkv(4'b1111, 0,  {8'd1, 8'd1, 8'd1, 8'd1}, {8'd6, 8'd6, 8'd6, 8'd6},    0, 30, 0, 0);
        vecs[1]  = mkv(4'b0101, 0,  {8'd1, 8'd1, 8'd1, 8'd1}, {8'd6, 8'd6, 8'd6, 8'd6},    1, 16, 0, 0);
        vecs[2]  = mkv(4'b0111, 0,  {8'd1, 8'd1, 8'd0, 8'd1}, {8'd6, 8'd2, 8'd0, 8'd3},    0, 10, 0, 0);
        vecs[3]  = mkv(4'b1111, 10, {8'd1, 8'd1, 8'd1, 8'd1}, {8'd6, 8'd255, 8'd6, 8'd6},  0, 26, 1, 2);
        vecs[4]  = mkv(4'b0001, 0,  {8'd1, 8'd1, 8'd1, 8'd2}, {8'd6, 8'd6, 8'd6, 8'd5},    0, 8,  0, 0);
        vecs[5]  = mkv(4'b0000, 0,  {8'd1, 8'd1, 8'd1, 8'd1}, {8'd6, 8'd6, 8'd6, 8'd6},    1, 2,  0, 0);
        vecs[6]  = mkv(4'b0001, 7,  {8'd1, 8'd1, 8'd1, 8'd1}, {8'd6, 8'd6, 8'd6, 8'd6},    0, 9,  0, 0);
        vecs[7]  = mkv(4'b0001, 6,  {8'd1, 8'd1, 8'd1, 8'd1}, {8'd6, 8'd6, 8'd6, 8'd6},    0, 8,  1, 0);
        vecs[8]  = mkv(4'b1000, 1,  {8'd0, 8'd1, 8'd1, 8'd1}, {8'd0, 8'd6, 8'd6, 8'd6},    0, 3,  0, 0);
        vecs[9]  = mkv(4'b0010, 3,  {8'd1, 8'd1, 8'd200, 8'd1}, {8'd6, 8'd6, 8'd255, 8'd6}, 0, 5, 1, 1);
        vecs[10] = mkv(4'b0010, 0,  {8'd1, 8'd1, 8'd255, 8'd1}, {8'd6, 8'd6, 8'd4, 8'd6},  1, 7,  0, 0);

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < N; k++) begin
                cfg_r[k]  = int'(vecs[i].r[k]);
                cfg_dn[k] = (vecs[i].dn[k] == 8'hff) ? NEVER : int'(vecs[i].dn[k]);
            end
            run_vec(vecs[i].mask, vecs[i].tmo, vecs[i].noise, int'(vecs[i].x_total),
                    vecs[i].x_err, int'(vecs[i].x_stg), $sformatf("vec%0d", i));
        end

        // Reset while waiting on stage 1
        @(posedge clock); #1;
        ap_start = 1'b1;
        stage_en = 4'b1111;
        timeout_cycles = '0;
        @(posedge clock); #1;                 // LAUNCH(0)
        check("rstrun/start0", 64'(stg_start), 64'(4'b0001));
        stg_ready = 4'b0001;
        @(posedge clock); #1;                 // WAIT(0)
        stg_ready = '0;
        stg_done = 4'b0001;
        @(posedge clock); #1;                 // LAUNCH(1)
        check("rstrun/start1", 64'(stg_start), 64'(4'b0010));
        stg_done = '0;
        stg_ready = 4'b0010;
        @(posedge clock); #1;                 // WAIT(1)
        stg_ready = '0;
        cnt_sel = '0;
        #1;
        check("rstrun/cnt0_pre", 64'(cnt_value), 2);
        reset = 1'b1;
        #1;
        check("rstrun/start", 64'(stg_start), 0);
        check("rstrun/idle", 64'(ap_idle), 1);
        check("rstrun/cnt0", 64'(cnt_value), 0);
        check("rstrun/total", 64'(total_cycles), 0);
        ap_start = 1'b0;
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        run_vec(4'b0000, 0, 0, 2, 0, 0, "after_rst");

        // Randomized runs
        for (int i = 0; i < 30; i++) begin
            logic [3:0]  rmask;
            logic [31:0] rtmo;
            rmask = 4'($urandom);
            rtmo  = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
            for (int k = 0; k < N; k++) begin
                cfg_r[k]  = $urandom_range(0, 6);
                cfg_dn[k] = $urandom_range(0, 12);
                if (rtmo != 0 && $urandom_range(0, 4) == 0) cfg_dn[k] = NEVER;
            end
            model(rmask, rtmo);
            run_vec(rmask, rtmo, 1, m_total, m_err, m_stg, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
